// File: rtl/ofifo_collector_if.sv
// Bus bundle of the output collector: column psums and write strobes in, aligned row and status out.
interface ofifo_collector_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16
);
   logic [col*psum_bw-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [col*psum_bw-1:0] out;
   logic                   o_valid;
   logic                   o_full;
   logic                   o_err;

   modport master (
      output in, wr, rd,
      input  out, o_valid, o_full, o_err
   );

   modport slave (
      input  in, wr, rd,
      output out, o_valid, o_full, o_err
   );
endinterface

// File: rtl/ofifo_collector.sv
// Per-column psum FIFOs released as one aligned row once every column is non-empty.
// Optional macro OFIFO_RELU_EN applies ReLU to each column as it is loaded into out.
module ofifo_collector #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic              clk,
   input  logic              reset,
   ofifo_collector_if.slave  bus
);
   localparam int AW = $clog2(depth);

   logic [col-1:0][AW:0]         wp_q, wp_d;
   logic [col-1:0][AW:0]         rp_q, rp_d;
   logic [col-1:0][psum_bw-1:0]  out_q, out_d;
   logic                         err_q, err_d;

   logic [col-1:0]               full;
   logic [col-1:0]               empty;
   logic [col-1:0]               wr_ok;
   logic [col-1:0][psum_bw-1:0]  head;
   logic [col-1:0][psum_bw-1:0]  head_v;
   logic                         valid;
   logic                         rd_ok;

   genvar gi;
   generate
      for (gi = 0; gi < col; gi++) begin : g_col
         logic [psum_bw-1:0] mem [depth];

         assign empty[gi] = (wp_q[gi] == rp_q[gi]);
         assign full[gi]  = (wp_q[gi][AW-1:0] == rp_q[gi][AW-1:0]) &&
                            (wp_q[gi][AW] != rp_q[gi][AW]);
         assign wr_ok[gi] = bus.wr[gi] && !full[gi];

         // Storage is deliberately left unreset; pointers alone define occupancy.
         always_ff @(posedge clk) begin
            if (wr_ok[gi])
               mem[wp_q[gi][AW-1:0]] <= bus.in[gi*psum_bw +: psum_bw];
         end

         assign head[gi] = mem[rp_q[gi][AW-1:0]];
`ifdef OFIFO_RELU_EN
         assign head_v[gi] = head[gi][psum_bw-1] ? '0 : head[gi];
`else
         assign head_v[gi] = head[gi];
`endif
      end
   endgenerate

   assign valid = &(~empty);
   assign rd_ok = bus.rd && valid;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      out_d = out_q;
      err_d = err_q;
      for (int k = 0; k < col; k++) begin
         if (wr_ok[k])
            wp_d[k] = wp_q[k] + 1'b1;
         if (rd_ok) begin
            rp_d[k]  = rp_q[k] + 1'b1;
            out_d[k] = head_v[k];
         end
      end
      // Full is sampled before the edge, so a write racing an accepted read is still an overflow.
      if ((|(bus.wr & full)) || (bus.rd && !valid))
         err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         out_q <= out_d;
         err_q <= err_d;
      end
   end

   assign bus.out     = out_q;
   assign bus.o_valid = valid;
   assign bus.o_full  = |full;
   assign bus.o_err   = err_q;
endmodule

// File: tb/tb_ofifo_collector.sv
// Scoreboard bench for ofifo_collector: per-column reference queues feed expected rows on accepted reads.
module tb_ofifo_collector;
   localparam int COL   = 8;
   localparam int PBW   = 16;
   localparam int DEPTH = 64;
   localparam int W     = COL*PBW;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ofifo_collector_if #(.col(COL), .psum_bw(PBW)) bus ();

   ofifo_collector #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [PBW-1:0] mq [COL][$];
   logic [W-1:0]   exp_q [$];
   logic [W-1:0]   m_out;
   logic           m_err;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [PBW-1:0] relu(input logic [PBW-1:0] v);
`ifdef OFIFO_RELU_EN
      return v[PBW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [W-1:0] rep(input logic [PBW-1:0] v);
      logic [W-1:0] r;
      for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = v;
      return r;
   endfunction

   function automatic logic m_valid();
      for (int k = 0; k < COL; k++) if (mq[k].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_full();
      for (int k = 0; k < COL; k++) if (mq[k].size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_status(input string tag);
      check_eq({tag, "_valid"}, W'(bus.o_valid), W'(m_valid()));
      check_eq({tag, "_full"},  W'(bus.o_full),  W'(m_full()));
      check_eq({tag, "_err"},   W'(bus.o_err),   W'(m_err));
   endtask

   task automatic cycle(input string tag, input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
      logic           pre_valid;
      logic [COL-1:0] pre_full;
      logic [W-1:0]   row;
      logic           popped;
      pre_valid = m_valid();
      for (int k = 0; k < COL; k++) pre_full[k] = (mq[k].size() == DEPTH);
      bus.wr = w;
      bus.in = d;
      bus.rd = r;
      @(posedge clk);
      #1;
      popped = 1'b0;
      if (r && pre_valid) begin
         for (int k = 0; k < COL; k++) row[k*PBW +: PBW] = relu(mq[k].pop_front());
         exp_q.push_back(row);
         popped = 1'b1;
      end else if (r) begin
         m_err = 1'b1;
      end
      for (int k = 0; k < COL; k++) begin
         if (w[k]) begin
            if (pre_full[k]) m_err = 1'b1;
            else mq[k].push_back(d[k*PBW +: PBW]);
         end
      end
      if (popped) m_out = exp_q.pop_front();
      check_eq({tag, "_out"}, bus.out, m_out);
      check_status(tag);
      bus.wr = '0;
      bus.rd = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      for (int k = 0; k < COL; k++) mq[k].delete();
      exp_q.delete();
      m_out = '0;
      m_err = 1'b0;
      check_eq({tag, "_out"}, bus.out, '0);
      check_status(tag);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [W-1:0] d;
      logic [PBW-1:0] v;
      bus.in = '0;
      bus.wr = '0;
      bus.rd = 1'b0;
      m_out  = '0;
      m_err  = 1'b0;
      repeat (2) @(posedge clk);
      do_reset("rst0");

      cycle("underflow", '0, '0, 1'b1);
      do_reset("rst1");

      for (int k = 0; k < COL; k++) begin
         d = '0;
         d[k*PBW +: PBW] = PBW'(16'h0010 + k);
         cycle("skew_wr", COL'(1) << k, d, 1'b0);
      end
      cycle("skew_rd", '0, '0, 1'b1);
      cycle("skew_idle", '0, '0, 1'b0);

      for (int i = 1; i <= DEPTH + 1; i++) cycle("ovf_wr0", COL'(1), W'(i), 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle("ovf_fill", ~COL'(1), rep(PBW'(16'h0100 + i)), 1'b0);
      for (int i = 0; i < DEPTH; i++) cycle("ovf_rd", '0, '0, 1'b1);
      cycle("ovf_drained", '0, '0, 1'b1);
      do_reset("rst2");

      cycle("conc_a", '1, rep(16'h0A0A), 1'b0);
      cycle("conc_b", '1, rep(16'h0B0B), 1'b0);
      cycle("conc_rdwr", '1, rep(16'h0C0C), 1'b1);
      cycle("conc_rd1", '0, '0, 1'b1);
      cycle("conc_rd2", '0, '0, 1'b1);

      for (int i = 0; i < 3; i++) cycle("mid_q", '1, rep(PBW'(16'h3000 + i)), 1'b0);
      do_reset("mid_rst");
      cycle("fresh_wr", '1, {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                             16'h3333, 16'h2222, 16'h1111, 16'h0000}, 1'b0);
      cycle("fresh_rd", '0, '0, 1'b1);

      cycle("wrap_first", '1, rep(16'hFFF0), 1'b0);
      for (int i = 1; i < 200; i++) begin
         v = (i % 2 == 0) ? 16'hFFF0 : 16'h0005;
         cycle("wrap_stream", '1, rep(v), 1'b1);
      end
      cycle("wrap_last", '0, '0, 1'b1);
      cycle("wrap_empty", '0, '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ofifo_collector.md
Name: ofifo_collector

Overview:
- Output collector directly downstream of the systolic MAC array; captures the south-edge partial sums (out_s of the bottom tile row), one column at a time.
- Columns drain with skew, one cycle apart, so each column owns a private FIFO.
- A full output row is released only when every column holds at least one entry. A single read pops all columns together and presents one aligned col-wide word to the SFU/psum memory.

Parameters:
- col, 8, number of array columns (independent column FIFOs)
- psum_bw, 16, partial-sum width per column (two's complement)
- depth, 64, entries per column FIFO; power of two, >= 2

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in  input  col*psum_bw  column psums; column k occupies bits [(k+1)*psum_bw-1 : k*psum_bw]
- wr  input  col  per-column write strobe (valid of the corresponding out_s)
- rd  input  1  pop one aligned row from all columns
- out  output  col*psum_bw  registered aligned row, same column packing as in
- o_valid  output  1  every column FIFO non-empty (a row is available)
- o_full  output  1  any column FIFO full
- o_err  output  1  sticky error: overflow write or underflow read seen

Behaviour:
- Reset (reset==0, async): all write/read pointers 0; out=0, o_valid=0, o_full=0, o_err=0. FIFO storage contents are not reset. Reset mid-operation discards all entries immediately; the first valid row after release needs col fresh writes.
- Pointers per column: log2(depth)+1 bits. The extra MSB separates full from empty. empty_k = (wp_k==rp_k). full_k = (addresses equal, MSBs differ). Pointers wrap naturally at 2*depth.
- Write: on posedge with wr[k]=1 and !full_k, store column k data at wp_k and increment wp_k. Columns are fully independent; any subset of wr may be high in a cycle.
- Overflow: wr[k]=1 while full_k. The write is dropped, wp_k is unchanged, and o_err is set.
- o_valid = AND of !empty_k over all columns. o_full = OR of full_k. Both are combinational from the pointers.
- Read: on posedge with rd=1 and o_valid=1, every rp_k increments, and out loads the head entries of all columns in that same edge. Read-to-out latency is 1 cycle.
- out holds its value until the next accepted read.
- Underflow: rd=1 while o_valid=0. No pointer moves, out is held, and o_err is set.
- Simultaneous rd and wr[k] on a non-empty column: both occur. Count is unchanged, and the head entry is read before the new entry lands.
- wr[k] on a full column in the same cycle as an accepted rd: treated as overflow (full_k is evaluated before the edge) and dropped.
- o_err is cleared only by reset.
- Latency, write to o_valid: the last column written at edge N gives o_valid=1 after edge N (visible in cycle N+1).

Optional Feature:
- Macro OFIFO_RELU_EN.
- Defined: each column value is passed through ReLU as it is loaded into out. Negative psum (MSB=1) becomes 0; non-negative values pass unchanged. FIFO storage is untouched.
- Undefined: out carries the raw stored psums bit-exactly.

Test Plan:
- Reset then skewed fill: col=8, write column k at cycle k with value 16'h0010+k. Required: o_valid=0 until after the column-7 write, then 1. Then rd=1 for one cycle gives out = {0017,...,0010} one cycle later, and o_valid returns to 0.
- Full/overflow: write column 0 depth+1 times (values 1..65). Required: o_full=1 after the 64th write, o_err=1 after the 65th. After filling the other columns, 64 reads return column 0 = 1..64, and the value 65 never appears.
- Underflow: empty FIFOs, rd=1. Required: out stays 0, o_err=1, and o_valid stays 0.
- Concurrent rd/wr: all columns hold 2 entries (A,B), then rd=1 with all wr=1 carrying C. Required: out=A, and the next two reads give B then C. No o_err.
- Async reset mid-stream: 3 rows queued, reset pulsed low between edges. Required: out=0, o_valid=0, and o_err=0 immediately, without waiting for a clock. A subsequent fresh row reads back correctly.
- Pointer wrap plus ReLU: stream 200 rows with alternating 16'hFFF0 and 16'h0005 through depth=64, reading continuously. Required: data is in order with no loss. With OFIFO_RELU_EN defined, out alternates 0000/0005; without it, FFF0/0005.
